axi_stream_insert_header: RTL and testbench
===========================================

// Module: axi_stream_insert_header
// PURPOSE
// - AXI-Stream header inserter: prepends a 0..DATA_BYTE_WD-1 byte header to each input packet.
// - Sits between a packet source and an AXI-Stream sink.
// - Output is the byte-realigned stream: header bytes, then packet bytes.
// - Byte order: the MSB byte lane is the first byte on the wire.
// PARAMETERS
// DATA_WD       32               data bus width in bits; multiple of 8, >=16
// DATA_BYTE_WD  DATA_WD/8        bytes per beat (derived)
// BYTE_CNT_WD   clog2(DATA_BYTE_WD)  width of byte_insert_cnt (derived)
// PORTS
// clk              in   1             single clock, all logic on rising edge
// rst_n            in   1             synchronous reset, ACTIVE-HIGH (port name kept per codebase)
// valid_in         in   1             input data beat valid
// data_in          in   DATA_WD       input data
// keep_in          in   DATA_BYTE_WD  byte enables; sampled only on last_in beat; MSB-aligned contiguous (1111/1110/1100/1000)
// last_in          in   1             last beat of input packet
// ready_in         out  1             input ready
// valid_out        out  1             output beat valid
// data_out         out  DATA_WD       output data
// keep_out         out  DATA_BYTE_WD  output byte enables, MSB-aligned contiguous
// last_out         out  1             last beat of output packet
// ready_out        in   1             downstream ready
// valid_insert     in   1             header valid
// data_insert      in   DATA_WD       header; valid bytes are the N least-significant bytes
// keep_insert      in   DATA_BYTE_WD  informational only; ignored by the block
// byte_insert_cnt  in   BYTE_CNT_WD   N = number of header bytes (0 = pass-through)
// ready_insert     out  1             header ready
// BEHAVIOUR
// - Reset, synchronous and active-high:
//   - valid_out=0, last_out=0, data_out=0, keep_out=0, ready_in=0, ready_insert=0.
//   - State=IDLE; residue register cleared.
//   - Reset mid-packet aborts the packet with no partial output.
// - Handshakes:
//   - A transfer occurs when valid&&ready on the same clock edge.
//   - Outputs hold stable while valid_out && !ready_out.
//   - No combinational valid->ready path.
// - IDLE:
//   - ready_insert=1, ready_in=0.
//   - Header handshake latches data_insert and N -> STREAM.
// - STREAM:
//   - ready_insert=0; ready_in follows output space.
//   - Non-last beat k:
//     - data_out = {residue[8N-1:0], data_in[DATA_WD-1:8N]}, keep_out=all ones.
//     - The residue is the header for the first beat, otherwise the previous beat's low N bytes.
//   - N=0: the beat passes through unchanged.
// - Last input beat, with K = popcount(keep_in):
//   - If N+K <= DATA_BYTE_WD: emit one beat, last_out=1, keep_out = top (N+K) lanes set -> IDLE.
//   - Else: emit a full beat (last_out=0), then FLUSH.
// - FLUSH:
//   - ready_in=0.
//   - Emit {residue, zeros} with keep_out = top (N+K-DATA_BYTE_WD) lanes set and last_out=1 -> IDLE.
// - Latency: first output beat valid one cycle after the first data_in handshake.
// - Throughput: one beat per clock while ready_out=1.
// - Data beats before the header is accepted are stalled (ready_in=0), never dropped.
// - Header and data arriving in the same cycle in IDLE: only the header is accepted.
// - last_in on the first beat is legal: single-beat packet.
// - Unused keep lanes drive data_out bytes to 0.
// CONFIGURATION
// AXIS_INSERT_SKID_EN
// - Defined:
//   - ready_in is a registered flop, backed by a 2-entry skid buffer.
//   - No combinational ready_out->ready_in path; full throughput.
// - Undefined:
//   - ready_in = (state==STREAM) && (!valid_out || ready_out), combinational from ready_out.
//   - Single output register.
// - Data sequence is identical in both builds.
// TESTING
// - DATA_WD=32, N=2, hdr=0x0000AABB, beats 0x01020304 and 0x05060708 (last, keep=1111):
//   - out AABB0102/1111, 03040506/1111, 0708_0000/keep 1100 last.
// - N=0, 3-beat packet, last keep=1110:
//   - output identical to input, last keep=1110.
// - N=3, hdr=0x00112233, single beat 0x44556677 (last, keep=1000):
//   - one beat 11223344, keep=1111, last=1.
// - Random valid_in/ready_out toggling, 76-beat packets:
//   - byte stream equals header||payload.
//   - No loss or duplication; data stable while stalled.
// - Reset asserted mid-packet:
//   - next cycle valid_out=0, ready_insert=1.
//   - The next packet is correct.
// - Data valid before the header (header delayed 15 cycles):
//   - ready_in=0 until the header handshake; no beats lost.

Source files
------------

// File: rtl/axi_stream_insert_header.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_insert_header
// Brief    : Prepends an N-byte header (0..DATA_BYTE_WD-1) to each AXI-Stream
//            packet and byte-realigns the payload (MSB lane first on the wire).
//            Define AXIS_INSERT_SKID_EN for a registered ready_in with skid buffer.
// Revision : 1.0 - initial release
// ============================================================================
module axi_stream_insert_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
    output logic                    ready_insert
);

    localparam int                      C_CW       = BYTE_CNT_WD + 1;
    localparam logic [DATA_BYTE_WD-1:0] C_KEEP_ALL = '1;
    localparam logic [C_CW-1:0]         C_BYTES    = C_CW'(DATA_BYTE_WD);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [BYTE_CNT_WD-1:0]  n_q;
    logic [C_CW-1:0]         rem_q;
    logic [DATA_WD-1:0]      residue_q;
    logic                    valid_out_q;
    logic                    last_out_q;
    logic                    ready_insert_q;
    logic [DATA_WD-1:0]      data_out_q;
    logic [DATA_BYTE_WD-1:0] keep_out_q;

    logic                    w_out_free;
    logic                    w_c_valid;
    logic                    w_c_last;
    logic                    w_c_pop;
    logic [DATA_WD-1:0]      w_c_data;
    logic [DATA_BYTE_WD-1:0] w_c_keep;
    logic [DATA_WD-1:0]      w_lo;
    logic [DATA_WD-1:0]      w_shift;
    logic [C_CW-1:0]         w_total;
    logic                    w_fits;
    logic [DATA_BYTE_WD-1:0] w_keep_nxt;
    logic [DATA_WD-1:0]      w_data_nxt;
    logic                    w_unused_keep_insert;

    function automatic logic [C_CW-1:0] f_popcount(input logic [DATA_BYTE_WD-1:0] k);
        logic [C_CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            cnt = cnt + C_CW'(k[i]);
        end
        return cnt;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] f_top_lanes(input logic [C_CW-1:0] cnt);
        logic [DATA_BYTE_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[i] = ((i + int'(cnt)) >= DATA_BYTE_WD);
        end
        return m;
    endfunction

    function automatic logic [DATA_WD-1:0] f_expand(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[8*i +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    assign w_unused_keep_insert = ^keep_insert;
    assign w_out_free           = !valid_out_q || ready_out;
    assign w_c_pop              = (state_q == S_STREAM) && w_out_free && w_c_valid;

`ifdef AXIS_INSERT_SKID_EN
    // Two-entry skid queue; when empty, the core consumes the input beat directly.
    localparam int C_FW = DATA_WD + DATA_BYTE_WD + 1;

    logic [C_FW-1:0] fifo_q [0:1];
    logic            rd_ptr_q;
    logic            wr_ptr_q;
    logic [1:0]      cnt_q;
    logic [1:0]      cnt_d;
    logic            in_open_q;
    logic            in_open_d;
    logic            ready_in_q;
    logic            w_in_hs;
    logic            w_fifo_pop;
    logic            w_push;

    assign w_in_hs    = valid_in && ready_in_q;
    assign w_c_valid  = (cnt_q != 2'd0) || w_in_hs;
    assign {w_c_last, w_c_keep, w_c_data} = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q]
                                                            : {last_in, keep_in, data_in};
    assign w_fifo_pop = w_c_pop && (cnt_q != 2'd0);
    assign w_push     = w_in_hs && !(w_c_pop && (cnt_q == 2'd0));
    assign cnt_d      = cnt_q + {1'b0, w_push} - {1'b0, w_fifo_pop};
    assign in_open_d  = (w_in_hs && last_in) ? 1'b0
                      : ((valid_insert && ready_insert_q) ? 1'b1 : in_open_q);
    assign ready_in   = ready_in_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            in_open_q  <= 1'b0;
            ready_in_q <= 1'b0;
        end else begin
            if (w_push)     wr_ptr_q <= !wr_ptr_q;
            if (w_fifo_pop) rd_ptr_q <= !rd_ptr_q;
            cnt_q      <= cnt_d;
            in_open_q  <= in_open_d;
            ready_in_q <= in_open_d && (cnt_d != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) fifo_q[wr_ptr_q] <= {last_in, keep_in, data_in};
    end
`else
    assign w_c_valid = valid_in;
    assign w_c_data  = data_in;
    assign w_c_keep  = keep_in;
    assign w_c_last  = last_in;
    assign ready_in  = (state_q == S_STREAM) && w_out_free;
`endif

    // Window of {residue, incoming} shifted so the N residue bytes lead the beat.
    always_comb begin
        w_lo    = (state_q == S_FLUSH) ? '0 : w_c_data;
        w_shift = DATA_WD'({residue_q, w_lo} >> {n_q, 3'b000});
        w_total = C_CW'(n_q) + f_popcount(w_c_keep);
        w_fits  = (w_total <= C_BYTES);
        if (state_q == S_FLUSH) begin
            w_keep_nxt = f_top_lanes(rem_q);
        end else if (w_c_last && w_fits) begin
            w_keep_nxt = f_top_lanes(w_total);
        end else begin
            w_keep_nxt = C_KEEP_ALL;
        end
        w_data_nxt = w_shift & f_expand(w_keep_nxt);
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q        <= S_IDLE;
            n_q            <= '0;
            rem_q          <= '0;
            residue_q      <= '0;
            valid_out_q    <= 1'b0;
            last_out_q     <= 1'b0;
            data_out_q     <= '0;
            keep_out_q     <= '0;
            ready_insert_q <= 1'b0;
        end else begin
            if (w_out_free) valid_out_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_insert_q <= 1'b1;
                    if (valid_insert && ready_insert_q) begin
                        state_q        <= S_STREAM;
                        n_q            <= byte_insert_cnt;
                        residue_q      <= data_insert;
                        ready_insert_q <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (w_c_pop) begin
                        valid_out_q <= 1'b1;
                        data_out_q  <= w_data_nxt;
                        keep_out_q  <= w_keep_nxt;
                        residue_q   <= w_c_data;
                        last_out_q  <= 1'b0;
                        if (w_c_last && w_fits) begin
                            last_out_q     <= 1'b1;
                            state_q        <= S_IDLE;
                            ready_insert_q <= 1'b1;
                        end else if (w_c_last) begin
                            rem_q   <= w_total - C_BYTES;
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_out_free) begin
                        valid_out_q    <= 1'b1;
                        data_out_q     <= w_data_nxt;
                        keep_out_q     <= w_keep_nxt;
                        last_out_q     <= 1'b1;
                        state_q        <= S_IDLE;
                        ready_insert_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign valid_out    = valid_out_q;
    assign data_out     = data_out_q;
    assign keep_out     = keep_out_q;
    assign last_out     = last_out_q;
    assign ready_insert = ready_insert_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_insert_header.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_stream_insert_header
// Brief    : Directed self-checking bench for axi_stream_insert_header (32-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_stream_insert_header;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        valid_insert;
    logic [31:0] data_insert;
    logic [3:0]  keep_insert;
    logic [1:0]  byte_insert_cnt;
    logic        ready_insert;

    int    errors = 0;
    int    checks = 0;
    logic  rnd    = 1'b0;
    beat_t obs_q[$];
    beat_t exp_q[$];
    logic [7:0]  byte_q[$];
    logic [31:0] pay_q[$];

    beat_t mon_cur;
    beat_t mon_prev;
    logic  mon_prev_stall = 1'b0;
    logic  mon_prev_rst   = 1'b1;

    axi_stream_insert_header #(.DATA_WD(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_in        (valid_in),
        .data_in         (data_in),
        .keep_in         (keep_in),
        .last_in         (last_in),
        .ready_in        (ready_in),
        .valid_out       (valid_out),
        .data_out        (data_out),
        .keep_out        (keep_out),
        .last_out        (last_out),
        .ready_out       (ready_out),
        .valid_insert    (valid_insert),
        .data_insert     (data_insert),
        .keep_insert     (keep_insert),
        .byte_insert_cnt (byte_insert_cnt),
        .ready_insert    (ready_insert)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Downstream ready: always high, or random while rnd is set.
    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready_out = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Output monitor: records accepted beats and checks stability under stall.
    always @(negedge clk) begin
        mon_cur = {data_out, keep_out, last_out};
        if (mon_prev_stall && !mon_prev_rst)
            check("stall_hold", {valid_out, mon_cur}, {1'b1, mon_prev});
        if (!rst_n && valid_out && ready_out) obs_q.push_back(mon_cur);
        mon_prev_stall = valid_out && !ready_out && !rst_n;
        mon_prev       = mon_cur;
        mon_prev_rst   = rst_n;
    end

    task automatic send_hdr(input logic [31:0] hdr, input logic [1:0] n);
        logic hs;
        hs              = 1'b0;
        valid_insert    = 1'b1;
        data_insert     = hdr;
        byte_insert_cnt = n;
        for (int c = 0; c < 1000 && !hs; c++) begin
            @(negedge clk);
            hs = ready_insert;
            @(posedge clk);
            #1;
        end
        valid_insert = 1'b0;
        if (!hs) check("hdr_timeout", hs, 1'b1);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input int gap);
        logic hs;
        hs = 1'b0;
        repeat (gap) begin
            valid_in = 1'b0;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        for (int c = 0; c < 1000 && !hs; c++) begin
            @(negedge clk);
            hs = ready_in;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        if (!hs) check("beat_timeout", hs, 1'b1);
    endtask

    task automatic wait_out(input int n);
        for (int c = 0; c < 500 && obs_q.size() < n; c++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] hdr;
        logic [1:0]  n;
        logic [3:0]  lk;
        logic        saw;
        beat_t       bt;
        int          kc;

        rst_n = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_insert = 1'b0; data_insert = '0; keep_insert = 4'hF; byte_insert_cnt = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_last_out", last_out, 1'b0);
        check("rst_data_out", data_out, 32'h0);
        check("rst_keep_out", keep_out, 4'h0);
        check("rst_ready_in", ready_in, 1'b0);
        check("rst_ready_insert", ready_insert, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("idle_ready_insert", ready_insert, 1'b1);
        check("idle_ready_in", ready_in, 1'b0);

        // N=2: header AABB spread across two beats plus a flush beat
        send_hdr(32'h0000AABB, 2'd2);
        send_beat(32'h01020304, 4'hF, 1'b0, 0);
        check("t1_latency_valid", valid_out, 1'b1);
        check("t1_latency_data", data_out, 32'hAABB0102);
        send_beat(32'h05060708, 4'hF, 1'b1, 0);
        wait_out(3);
        check("t1_count", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            check("t1_beat0", obs_q[0], {32'hAABB0102, 4'hF, 1'b0});
            check("t1_beat1", obs_q[1], {32'h03040506, 4'hF, 1'b0});
            check("t1_beat2", obs_q[2], {32'h07080000, 4'hC, 1'b1});
        end
        obs_q.delete();

        // N=0: pass-through, last keep=1110
        send_hdr(32'h0, 2'd0);
        send_beat(32'hA1A2A3A4, 4'hF, 1'b0, 0);
        send_beat(32'hB1B2B3B4, 4'hF, 1'b0, 1);
        send_beat(32'hC1C2C300, 4'hE, 1'b1, 0);
        wait_out(3);
        check("t2_count", obs_q.size(), 3);
        if (obs_q.size() == 3) begin
            check("t2_beat0", obs_q[0], {32'hA1A2A3A4, 4'hF, 1'b0});
            check("t2_beat1", obs_q[1], {32'hB1B2B3B4, 4'hF, 1'b0});
            check("t2_beat2", obs_q[2], {32'hC1C2C300, 4'hE, 1'b1});
        end
        obs_q.delete();

        // N=3 single-beat packet filling exactly one beat
        send_hdr(32'h00112233, 2'd3);
        send_beat(32'h44556677, 4'h8, 1'b1, 0);
        check("t3_latency_valid", valid_out, 1'b1);
        check("t3_latency_data", data_out, 32'h11223344);
        wait_out(1);
        check("t3_count", obs_q.size(), 1);
        if (obs_q.size() == 1) check("t3_beat0", obs_q[0], {32'h11223344, 4'hF, 1'b1});
        obs_q.delete();

        // Reset asserted mid-packet
        send_hdr(32'h0000AABB, 2'd2);
        send_beat(32'h01020304, 4'hF, 1'b0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t4_rst_valid_out", valid_out, 1'b0);
        check("t4_rst_ready_in", ready_in, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t4_ready_insert", ready_insert, 1'b1);
        check("t4_valid_out", valid_out, 1'b0);
        obs_q.delete();

        // Data presented 15 cycles before the header
        valid_in = 1'b1; data_in = 32'hDEADBEEF; keep_in = 4'hF; last_in = 1'b0;
        saw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (ready_in) saw = 1'b1;
            @(posedge clk);
            #1;
        end
        check("t5_early_ready_in", saw, 1'b0);
        send_hdr(32'h000000CC, 2'd1);
        send_beat(32'hDEADBEEF, 4'hF, 1'b0, 0);
        send_beat(32'h12345678, 4'hC, 1'b1, 0);
        wait_out(2);
        check("t5_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("t5_beat0", obs_q[0], {32'hCCDEADBE, 4'hF, 1'b0});
            check("t5_beat1", obs_q[1], {32'hEF123400, 4'hE, 1'b1});
        end
        obs_q.delete();

        // Long packets with random input gaps and downstream back-pressure
        rnd = 1'b1;
        for (int p = 0; p < 3; p++) begin
            n   = 2'(p + 1);
            hdr = $urandom;
            lk  = (p == 0) ? 4'h8 : ((p == 1) ? 4'hE : 4'hF);
            pay_q.delete(); byte_q.delete(); exp_q.delete(); obs_q.delete();
            for (int i = 0; i < 76; i++) pay_q.push_back($urandom);
            for (int i = int'(n) - 1; i >= 0; i--) byte_q.push_back(hdr[8*i +: 8]);
            for (int i = 0; i < 76; i++) begin
                kc = (i == 75) ? $countones(lk) : 4;
                for (int j = 0; j < kc; j++) byte_q.push_back(pay_q[i][31-8*j -: 8]);
            end
            for (int i = 0; i < byte_q.size(); i += 4) begin
                bt = '0;
                for (int j = 0; j < 4; j++) begin
                    if (i + j < byte_q.size()) begin
                        bt.d[31-8*j -: 8] = byte_q[i+j];
                        bt.k[3-j]         = 1'b1;
                    end
                end
                bt.l = (i + 4 >= byte_q.size());
                exp_q.push_back(bt);
            end
            send_hdr(hdr, n);
            for (int i = 0; i < 76; i++)
                send_beat(pay_q[i], (i == 75) ? lk : 4'hF, i == 75,
                          ($urandom_range(0, 3) == 0) ? 1 : 0);
            wait_out(exp_q.size());
            check($sformatf("rnd%0d_count", p), obs_q.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
                check($sformatf("rnd%0d_beat%0d", p, i), obs_q[i], exp_q[i]);
        end
        rnd = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
